// File: rtl/ad9361_sim_pkg.sv
// ad9361_sim_pkg
// Shared definitions for the AD9361 receive-side pattern generator:
//   - pattern mode encodings carried on the 2-bit mode input
//   - generator state encoding
//   - PRBS15 (x^15 + x^14 + 1) tap positions and stepping helpers
package ad9361_sim_pkg;

  localparam logic [1:0] MODE_CNT   = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_PRBS  = 2'd2;
  localparam logic [1:0] MODE_CONST = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } gen_state_t;

  // Bit positions feeding the PRBS15 XOR (x^15 and x^14 terms).
  localparam int PRBS15_LEN    = 15;
  localparam int PRBS15_TAP_HI = 14;
  localparam int PRBS15_TAP_LO = 13;

  function automatic logic [PRBS15_LEN-1:0] prbs15_next(input logic [PRBS15_LEN-1:0] s);
    return {s[PRBS15_LEN-2:0], s[PRBS15_TAP_HI] ^ s[PRBS15_TAP_LO]};
  endfunction

  // Advances the register n steps; used both at elaboration (per-channel
  // seeds) and in hardware with a constant n, so the loop fully unrolls.
  function automatic logic [PRBS15_LEN-1:0] prbs15_advance(input logic [PRBS15_LEN-1:0] s,
                                                          input int unsigned n);
    logic [PRBS15_LEN-1:0] r;
    r = s;
    for (int unsigned i = 0; i < n; i++) begin
      r = prbs15_next(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/ad9361_prbs15.sv
// ad9361_prbs15
// PRBS15 generator that advances a fixed number of steps whenever step is
// high, and reloads its seed when load is high.
// Ports:
//   clk     word clock
//   resetn  asynchronous active-low reset, restores SEED
//   load    synchronous reload of SEED (takes priority over step)
//   step    advance the register by STEPS positions
//   prbs    low OUT_WIDTH bits of the current register value
module ad9361_prbs15
  import ad9361_sim_pkg::*;
#(
  parameter int                    OUT_WIDTH = 12,
  parameter logic [PRBS15_LEN-1:0] SEED      = 15'h7FFF,
  parameter int                    STEPS     = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 step,
  output logic [OUT_WIDTH-1:0] prbs
);

  logic [PRBS15_LEN-1:0] lfsr;

  // One register per channel slot; a frame period consumes STEPS slots, so
  // each instance jumps over the slots owned by the other channels.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= prbs15_advance(lfsr, STEPS);
    end
  end

  assign prbs = lfsr[OUT_WIDTH-1:0];

endmodule

// File: rtl/ad9361_rx_pattern_gen.sv
// ad9361_rx_pattern_gen
// AD9361 LVDS receive-side stimulus source. Serialises NUM_CHANNELS I/Q
// sample pairs into half-width lane words, marks frames, and starts/stops
// only on frame-period boundaries.
// Ports:
//   clk         word clock, one rx_data word per cycle
//   resetn      asynchronous active-low reset
//   enable      level request for pattern generation
//   mode        0 counter, 1 ramp, 2 PRBS15, 3 constant (taken at period start)
//   const_i     I value for the constant pattern
//   const_q     Q value for the constant pattern
//   rx_frame    high for the first half of every frame period
//   rx_data     lane word (SAMPLE_WIDTH/2 bits)
//   busy        high while running or draining the final period
//   sample_cnt  completed frame periods since the last start (wraps)
module ad9361_rx_pattern_gen
  import ad9361_sim_pkg::*;
#(
  parameter int                    SAMPLE_WIDTH = 12,
  parameter int                    NUM_CHANNELS = 1,
  parameter logic [PRBS15_LEN-1:0] PRBS_SEED    = 15'h7FFF,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [SAMPLE_WIDTH-1:0]   const_i,
  input  logic [SAMPLE_WIDTH-1:0]   const_q,
  output logic                      rx_frame,
  output logic [SAMPLE_WIDTH/2-1:0] rx_data,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      sample_cnt
);

  localparam int DW    = SAMPLE_WIDTH / 2;
  localparam int F     = 4 * NUM_CHANNELS;
  localparam int HALF  = 2 * NUM_CHANNELS;
  localparam int IDX_W = $clog2(F);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(F - 1);
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(HALF);

  gen_state_t              state;
  logic [IDX_W-1:0]        word_idx;
  logic [1:0]              cur_mode;
  logic [SAMPLE_WIDTH-1:0] cur_i;
  logic [SAMPLE_WIDTH-1:0] cur_q;

  logic                    last_word;
  logic                    prbs_load;
  logic                    prbs_step;
  logic [SAMPLE_WIDTH-1:0] k_sw;
  logic [SAMPLE_WIDTH-1:0] prbs_val [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] samp_i   [NUM_CHANNELS];
  logic [SAMPLE_WIDTH-1:0] samp_q   [NUM_CHANNELS];
  logic [DW-1:0]           word_sel;

  assign last_word = (word_idx == LAST_IDX);
  assign k_sw      = SAMPLE_WIDTH'(sample_cnt);

  // The LFSRs advance at every period end regardless of mode, so PRBS
  // slot n always corresponds to channel n % NCH of period n / NCH.
  assign prbs_load = (state == IDLE) && enable;
  assign prbs_step = (state != IDLE) && last_word;

  // Channel c's register starts c steps ahead of the seed and skips
  // NUM_CHANNELS steps per period, interleaving the slots across channels.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_prbs
    ad9361_prbs15 #(
      .OUT_WIDTH (SAMPLE_WIDTH),
      .SEED      (prbs15_advance(PRBS_SEED, c)),
      .STEPS     (NUM_CHANNELS)
    ) u_prbs (
      .clk    (clk),
      .resetn (resetn),
      .load   (prbs_load),
      .step   (prbs_step),
      .prbs   (prbs_val[c])
    );
  end

  // Per-channel I/Q values for the current period, from the latched mode.
  always_comb begin
    logic [SAMPLE_WIDTH-1:0] chan_k;
    chan_k = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      samp_i[c] = '0;
      samp_q[c] = '0;
      chan_k    = k_sw + SAMPLE_WIDTH'(c);
      case (cur_mode)
        MODE_CNT: begin
          samp_i[c] = k_sw;
          samp_q[c] = k_sw;
        end
        MODE_RAMP: begin
          samp_i[c] = chan_k;
          samp_q[c] = ~chan_k;
        end
        MODE_PRBS: begin
          samp_i[c] = prbs_val[c];
          samp_q[c] = ~prbs_val[c];
        end
        MODE_CONST: begin
          samp_i[c] = cur_i;
          samp_q[c] = cur_q;
        end
      endcase
    end
  end

  // The first half of a period carries the MSB halves (I then Q for each
  // channel in turn), the second half the LSB halves in the same order.
  always_comb begin
    word_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (word_idx == IDX_W'(2 * c))            word_sel = samp_i[c][SAMPLE_WIDTH-1:DW];
      if (word_idx == IDX_W'(2 * c + 1))        word_sel = samp_q[c][SAMPLE_WIDTH-1:DW];
      if (word_idx == IDX_W'(HALF + 2 * c))     word_sel = samp_i[c][DW-1:0];
      if (word_idx == IDX_W'(HALF + 2 * c + 1)) word_sel = samp_q[c][DW-1:0];
    end
  end

  // Control FSM. Words are registered, so the first word follows the start
  // edge by one cycle; a period, once begun, always runs to its last word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      word_idx   <= '0;
      sample_cnt <= '0;
      rx_frame   <= 1'b0;
      rx_data    <= '0;
      busy       <= 1'b0;
      cur_mode   <= MODE_CNT;
      cur_i      <= '0;
      cur_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          rx_frame <= 1'b0;
          rx_data  <= '0;
          word_idx <= '0;
          if (enable) begin
            state      <= RUN;
            busy       <= 1'b1;
            sample_cnt <= '0;
            cur_mode   <= mode;
            cur_i      <= const_i;
            cur_q      <= const_q;
          end
        end
        RUN, DRAIN: begin
          rx_frame <= (word_idx < HALF_IDX);
          rx_data  <= word_sel;
          if (last_word) begin
            word_idx   <= '0;
            sample_cnt <= sample_cnt + CNT_WIDTH'(1);
            cur_mode   <= mode;
            cur_i      <= const_i;
            cur_q      <= const_q;
            // A drain request stays sticky even if enable comes back.
            if ((state == DRAIN) || !enable) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            word_idx <= word_idx + IDX_W'(1);
            if (!enable) begin
              state <= DRAIN;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9361_rx_pattern_gen.sv
// tb_ad9361_rx_pattern_gen
// Drives a 1R1T instance (32-bit counter) and a 2R2T instance (5-bit
// counter, so wrap-around is reachable) with identical stimulus and
// compares both against a period-level reference model every cycle.
module tb_ad9361_rx_pattern_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] const_i;
  logic [11:0] const_q;

  logic        frame_a, frame_b;
  logic        busy_a, busy_b;
  logic [5:0]  data_a, data_b;
  logic [31:0] cnt_a;
  logic [4:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ad9361_rx_pattern_gen #(
    .SAMPLE_WIDTH (12),
    .NUM_CHANNELS (1),
    .PRBS_SEED    (15'h7FFF),
    .CNT_WIDTH    (32)
  ) dut_a (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .mode       (mode),
    .const_i    (const_i),
    .const_q    (const_q),
    .rx_frame   (frame_a),
    .rx_data    (data_a),
    .busy       (busy_a),
    .sample_cnt (cnt_a)
  );

  ad9361_rx_pattern_gen #(
    .SAMPLE_WIDTH (12),
    .NUM_CHANNELS (2),
    .PRBS_SEED    (15'h7FFF),
    .CNT_WIDTH    (5)
  ) dut_b (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .mode       (mode),
    .const_i    (const_i),
    .const_q    (const_q),
    .rx_frame   (frame_b),
    .rx_data    (data_b),
    .busy       (busy_b),
    .sample_cnt (cnt_b)
  );

  // Reference model state, index 0 = 1R1T instance, 1 = 2R2T instance.
  logic [14:0] prbs_seq [8192];
  bit          m_active [2];
  bit          m_stop   [2];
  int unsigned m_k      [2];
  int unsigned m_pos    [2];
  logic [1:0]  m_mode   [2];
  logic [11:0] m_ci     [2];
  logic [11:0] m_cq     [2];
  logic [5:0]  m_data   [2][8];
  logic        exp_frame[2];
  logic [5:0]  exp_data [2];
  logic        exp_busy [2];

  logic [5:0] mode0_words [8];
  logic [5:0] const_words [4];
  logic [5:0] ramp_words  [8];
  logic       frame_1ch   [4];
  logic       frame_2ch   [8];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] prbsNext(input logic [14:0] s);
    int unsigned v;
    int unsigned fb;
    v  = int'(s);
    fb = ((v >> 14) ^ (v >> 13)) & 1;
    return 15'(((v << 1) | fb) & 32'h7FFF);
  endfunction

  // Builds the expected words of the period the model is about to emit.
  function automatic void modelFill(input int d);
    int          nch;
    int unsigned kval;
    int unsigned slot;
    int          c;
    logic [11:0] smp_i [2];
    logic [11:0] smp_q [2];
    logic [11:0] s;
    nch   = d + 1;
    kval  = (d == 0) ? m_k[d] : (m_k[d] % 32);
    kval  = kval % 4096;
    smp_i = '{12'h000, 12'h000};
    smp_q = '{12'h000, 12'h000};
    for (int ch = 0; ch < nch; ch++) begin
      case (m_mode[d])
        2'd0: begin
          smp_i[ch] = 12'(kval);
          smp_q[ch] = 12'(kval);
        end
        2'd1: begin
          smp_i[ch] = 12'((kval + ch) % 4096);
          smp_q[ch] = 12'(4095 - ((kval + ch) % 4096));
        end
        2'd2: begin
          slot      = m_k[d] * nch + ch;
          smp_i[ch] = prbs_seq[slot][11:0];
          smp_q[ch] = 12'(4095 - int'(smp_i[ch]));
        end
        default: begin
          smp_i[ch] = m_ci[d];
          smp_q[ch] = m_cq[d];
        end
      endcase
    end
    for (int w = 0; w < 4 * nch; w++) begin
      c = (w % (2 * nch)) / 2;
      s = ((w % 2) == 1) ? smp_q[c] : smp_i[c];
      m_data[d][w] = (w < 2 * nch) ? 6'(s / 64) : 6'(s % 64);
    end
  endfunction

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      m_active[d]  = 1'b0;
      m_stop[d]    = 1'b0;
      m_k[d]       = 0;
      m_pos[d]     = 0;
      exp_frame[d] = 1'b0;
      exp_data[d]  = '0;
      exp_busy[d]  = 1'b0;
    end
  endfunction

  // Advances the model across one clock edge with the inputs seen there.
  function automatic void modelStep(input int d, input bit en, input logic [1:0] md,
                                    input logic [11:0] ci, input logic [11:0] cq);
    int nch;
    nch = d + 1;
    if (!m_active[d]) begin
      exp_frame[d] = 1'b0;
      exp_data[d]  = '0;
      if (en) begin
        m_active[d] = 1'b1;
        m_stop[d]   = 1'b0;
        m_k[d]      = 0;
        m_pos[d]    = 0;
        m_mode[d]   = md;
        m_ci[d]     = ci;
        m_cq[d]     = cq;
        modelFill(d);
      end
    end else begin
      exp_frame[d] = (m_pos[d] < 2 * nch);
      exp_data[d]  = m_data[d][m_pos[d]];
      if (m_pos[d] == 4 * nch - 1) begin
        m_k[d]    = m_k[d] + 1;
        m_pos[d]  = 0;
        m_mode[d] = md;
        m_ci[d]   = ci;
        m_cq[d]   = cq;
        if (m_stop[d] || !en) m_active[d] = 1'b0;
        else                  modelFill(d);
      end else begin
        m_pos[d] = m_pos[d] + 1;
        if (!en) m_stop[d] = 1'b1;
      end
    end
    exp_busy[d] = m_active[d];
  endfunction

  task automatic checkModel();
    checkOutput("a.frame", frame_a, exp_frame[0]);
    checkOutput("a.data",  data_a,  exp_data[0]);
    checkOutput("a.busy",  busy_a,  exp_busy[0]);
    checkOutput("a.cnt",   cnt_a,   m_k[0]);
    checkOutput("b.frame", frame_b, exp_frame[1]);
    checkOutput("b.data",  data_b,  exp_data[1]);
    checkOutput("b.busy",  busy_b,  exp_busy[1]);
    checkOutput("b.cnt",   cnt_b,   m_k[1] % 32);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check 1 later.
  task automatic applyStimulus(input bit en, input logic [1:0] md,
                               input logic [11:0] ci, input logic [11:0] cq);
    @(negedge clk);
    enable  = en;
    mode    = md;
    const_i = ci;
    const_q = cq;
    @(posedge clk);
    if (resetn) begin
      modelStep(0, en, md, ci, cq);
      modelStep(1, en, md, ci, cq);
    end else begin
      modelReset();
    end
    #1;
    checkModel();
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 12'h000, 12'h000);
  endtask

  task automatic doReset();
    resetn = 1'b0;
    modelReset();
    #1;
    checkModel();
    applyStimulus(1'b0, 2'd0, 12'h000, 12'h000);
    applyStimulus(1'b0, 2'd0, 12'h000, 12'h000);
    resetn = 1'b1;
  endtask

  initial begin
    bit          en_r;
    logic [1:0]  md_r;

    mode0_words = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h01};
    const_words = '{6'h2A, 6'h04, 6'h3C, 6'h23};
    ramp_words  = '{6'h00, 6'h3F, 6'h00, 6'h3F, 6'h02, 6'h3D, 6'h03, 6'h3C};
    frame_1ch   = '{1'b1, 1'b1, 1'b0, 1'b0};
    frame_2ch   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    prbs_seq[0] = 15'h7FFF;
    for (int i = 1; i < 8192; i++) prbs_seq[i] = prbsNext(prbs_seq[i-1]);

    resetn  = 1'b0;
    enable  = 1'b0;
    mode    = 2'd0;
    const_i = '0;
    const_q = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkModel();
    resetn = 1'b1;

    // Counter pattern with enable held from reset release.
    for (int t = 1; t <= 9; t++) begin
      applyStimulus(1'b1, 2'd0, 12'h000, 12'h000);
      if (t == 1) checkOutput("p1.busy_start", busy_a, 1);
      if (t >= 2) begin
        checkOutput("p1.word",  data_a,  mode0_words[t-2]);
        checkOutput("p1.frame", frame_a, frame_1ch[(t-2)%4]);
      end
    end
    for (int t = 0; t < 24; t++) applyStimulus(1'b1, 2'd0, 12'h000, 12'h000);
    runIdle(10);

    // Constant pattern.
    for (int t = 1; t <= 13; t++) begin
      applyStimulus(1'b1, 2'd3, 12'hABC, 12'h123);
      if (t >= 2) begin
        checkOutput("p2.word", data_a, const_words[(t-2)%4]);
        checkOutput("p2.cnt",  cnt_a,  (t-1)/4);
      end
    end
    runIdle(10);

    // Ramp on the 2R2T instance, third period.
    for (int t = 1; t <= 25; t++) begin
      applyStimulus(1'b1, 2'd1, 12'h000, 12'h000);
      if (t >= 18) begin
        checkOutput("p3.word",  data_b,  ramp_words[t-18]);
        checkOutput("p3.frame", frame_b, frame_2ch[t-18]);
      end
    end
    runIdle(10);

    // Enable drops at word 1 of the second 1R1T period.
    for (int t = 1; t <= 10; t++) begin
      applyStimulus(t <= 6, 2'd0, 12'h000, 12'h000);
      if (t == 7) checkOutput("p4.cnt_before", cnt_a, 1);
      if (t == 8) checkOutput("p4.word2", data_a, 6'h01);
      if (t == 9) begin
        checkOutput("p4.word3", data_a, 6'h01);
        checkOutput("p4.cnt",   cnt_a,  2);
      end
      if (t == 10) begin
        checkOutput("p4.busy",  busy_a,  0);
        checkOutput("p4.frame", frame_a, 0);
        checkOutput("p4.data",  data_a,  0);
        checkOutput("p4.cnt_after", cnt_a, 2);
      end
    end
    runIdle(4);

    // PRBS: long run from reset, then a second run from reset.
    doReset();
    for (int t = 1; t <= 4001; t++) begin
      applyStimulus(1'b1, 2'd2, 12'h000, 12'h000);
      if (t == 2)    checkOutput("p5.first_msb", data_a, 6'h3F);
      if (t == 3)    checkOutput("p5.first_q",   data_a, 6'h00);
      if (t == 256)  checkOutput("p5.b_cnt_max", cnt_b,  31);
      if (t == 257)  checkOutput("p5.b_cnt_wrap", cnt_b, 0);
      if (t == 4001) checkOutput("p5.a_cnt",     cnt_a,  1000);
    end
    runIdle(10);
    doReset();
    for (int t = 1; t <= 41; t++) begin
      applyStimulus(1'b1, 2'd2, 12'h000, 12'h000);
      if (t == 2) checkOutput("p5.rerun_msb", data_a, 6'h3F);
    end
    runIdle(10);

    // Asynchronous reset in the middle of a period.
    for (int t = 1; t <= 4; t++) applyStimulus(1'b1, 2'd0, 12'h000, 12'h000);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("p6.a_frame", frame_a, 0);
    checkOutput("p6.a_data",  data_a,  0);
    checkOutput("p6.a_busy",  busy_a,  0);
    checkOutput("p6.a_cnt",   cnt_a,   0);
    checkOutput("p6.b_busy",  busy_b,  0);
    checkOutput("p6.b_data",  data_b,  0);
    modelReset();
    applyStimulus(1'b1, 2'd0, 12'h000, 12'h000);
    resetn = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      applyStimulus(1'b1, 2'd0, 12'h000, 12'h000);
      if (t == 1) begin
        checkOutput("p6.busy_restart",  busy_a,  1);
        checkOutput("p6.frame_restart", frame_a, 0);
      end
      if (t == 2) begin
        checkOutput("p6.word0_frame", frame_a, 1);
        checkOutput("p6.word0_cnt",   cnt_a,   0);
      end
    end
    runIdle(10);

    // Random enable toggling, mid-period mode and constant changes.
    en_r = 1'b0;
    md_r = 2'd0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      if ($urandom_range(0, 3) == 0)  md_r = 2'($urandom_range(0, 3));
      applyStimulus(en_r, md_r, 12'($urandom), 12'($urandom));
    end
    runIdle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
